// File: rtl/bcd_count_ctrl.sv
// Start/pause/load sequencer for a chain of decade counter digits, with tick prescaler and terminal match.
// Define BCD_DOWN_COUNT_EN to add the `dir` input (1 = count down).
//
// state | meaning
// IDLE  | loaded or reset, waiting for start
// RUN   | prescaler running, count advances on each tick
// PAUSE | frozen, prescaler keeps its partial progress
// DONE  | count reached limit; start restarts from zero
module bcd_count_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  load,
`ifdef BCD_DOWN_COUNT_EN
  input  logic                  dir,
`endif
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic [4*DIGITS-1:0]   limit,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic [DIGITS-1:0]     carry,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int W  = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t          st, st_nxt;
  logic [PW-1:0]   presc, presc_nxt;
  logic [W-1:0]    q_nxt, q_step, ld_clean;
  logic [DIGITS-1:0] carry_nxt, carry_step;
  logic            tick_nxt, done_nxt, presc_tc, down;

`ifdef BCD_DOWN_COUNT_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  assign presc_tc = (presc == PW'(PRESCALE - 1));
  assign state    = st;
  assign busy     = (st == S_RUN) || (st == S_PAUSE);

  // Non-BCD preset digits are forced to zero so the chain never holds an illegal code.
  always_comb begin
    ld_clean = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] <= 4'd9) ld_clean[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  // Ripple increment/decrement: a digit moves only while every lower digit wrapped.
  always_comb begin
    logic       ripple;
    logic [3:0] dig;
    q_step     = q;
    carry_step = '0;
    ripple     = 1'b1;
    dig        = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q[4*i +: 4];
      if (ripple) begin
        if (down) begin
          if (dig == 4'd0) begin
            q_step[4*i +: 4] = 4'd9;
            carry_step[i]    = 1'b1;
          end else begin
            q_step[4*i +: 4] = dig - 4'd1;
            ripple           = 1'b0;
          end
        end else begin
          if (dig >= 4'd9) begin
            q_step[4*i +: 4] = 4'd0;
            carry_step[i]    = 1'b1;
          end else begin
            q_step[4*i +: 4] = dig + 4'd1;
            ripple           = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    st_nxt    = st;
    presc_nxt = presc;
    q_nxt     = q;
    tick_nxt  = 1'b0;
    carry_nxt = '0;
    done_nxt  = 1'b0;
    if (load) begin
      q_nxt     = ld_clean;
      presc_nxt = '0;
      st_nxt    = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE, S_PAUSE: begin
          if (start && !stop) st_nxt = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            st_nxt = S_PAUSE;
          end else if (presc_tc) begin
            presc_nxt = '0;
            tick_nxt  = 1'b1;
            q_nxt     = q_step;
            carry_nxt = carry_step;
            if (q_step == limit) begin
              st_nxt   = S_DONE;
              done_nxt = 1'b1;
            end
          end else begin
            presc_nxt = presc + 1'b1;
          end
        end
        S_DONE: begin
          if (start && !stop) begin
            st_nxt = S_RUN;
            q_nxt  = '0;
          end
        end
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      st    <= S_IDLE;
      presc <= '0;
      q     <= '0;
      tick  <= 1'b0;
      carry <= '0;
      done  <= 1'b0;
    end else begin
      st    <= st_nxt;
      presc <= presc_nxt;
      q     <= q_nxt;
      tick  <= tick_nxt;
      carry <= carry_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench for bcd_count_ctrl (2 digits, prescale 3): directed scenarios plus
// randomized control traffic checked against an integer-valued reference model.
module tb_bcd_count_ctrl;
  localparam int DIGITS   = 2;
  localparam int PRESCALE = 3;

  logic       clk = 1'b0;
  logic       clr = 1'b0, start = 1'b0, stop = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00, limit = 8'h99;
  logic [7:0] q;
  logic       tick, busy, done;
  logic [1:0] carry, state;

  int tests_run = 0, tests_failed = 0;

  // Reference model: count held as a plain integer 0..99.
  int         m_state = 0, m_n = 0, m_p = 0;
  logic       m_tick = 1'b0, m_done = 1'b0;
  logic [1:0] m_carry = 2'b00;

  always #5 clk = ~clk;

  bcd_count_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .clr(clr), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .limit(limit), .q(q), .tick(tick), .carry(carry),
    .busy(busy), .done(done), .state(state)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, got no finish, expected finish");
    $fatal(1);
  end

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic model_step();
    int d1, d0;
    m_tick  = 1'b0;
    m_carry = 2'b00;
    m_done  = 1'b0;
    if (!clr) begin
      m_state = 0; m_n = 0; m_p = 0;
    end else if (load) begin
      d1 = (load_val[7:4] > 4'd9) ? 0 : int'(load_val[7:4]);
      d0 = (load_val[3:0] > 4'd9) ? 0 : int'(load_val[3:0]);
      m_n = d1 * 10 + d0; m_p = 0; m_state = 0;
    end else begin
      case (m_state)
        0, 2: if (start && !stop) m_state = 1;
        1: begin
          if (stop) m_state = 2;
          else if (m_p == PRESCALE - 1) begin
            m_p = 0;
            m_tick = 1'b1;
            m_carry[0] = (m_n % 10 == 9);
            m_carry[1] = (m_n == 99);
            m_n = (m_n + 1) % 100;
            if (limit[7:4] <= 4'd9 && limit[3:0] <= 4'd9 &&
                m_n == int'(limit[7:4]) * 10 + int'(limit[3:0])) begin
              m_state = 3;
              m_done  = 1'b1;
            end
          end else m_p++;
        end
        default: if (start && !stop) begin m_state = 1; m_n = 0; end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load_val = v; load = 1'b1; cyc(); load = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; cyc(); cyc();
    tests_run++;
    if ({q, tick, carry, busy, done, state} !== 15'h0) begin
      tests_failed++;
      $display("FAIL reset_initial: got %h expected %h", {q, tick, carry, busy, done, state}, 15'h0);
    end
    clr = 1'b1; limit = 8'h99;
    do_load(8'h36);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc(); cyc();
    tests_run++;
    if ({q, state} !== {8'h37, 2'b01}) begin
      tests_failed++;
      $display("FAIL reset_setup_q37: got %h expected %h", {q, state}, {8'h37, 2'b01});
    end
    clr = 1'b0; cyc(); clr = 1'b1;
    tests_run++;
    if ({q, tick, carry, busy, done, state} !== 15'h0) begin
      tests_failed++;
      $display("FAIL reset_midrun: got %h expected %h", {q, tick, carry, busy, done, state}, 15'h0);
    end
    cyc();
    tests_run++;
    if ({q, tick, carry, busy, done, state} !== 15'h0) begin
      tests_failed++;
      $display("FAIL reset_after: got %h expected %h", {q, tick, carry, busy, done, state}, 15'h0);
    end
  endtask

  task automatic test_basic_count();
    logic [11:0] exp;
    limit = 8'h99;
    do_load(8'h00);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      exp = {to_bcd(k / 3), (k % 3 == 0), (k == 30) ? 2'b01 : 2'b00, 1'b1};
      tests_run++;
      if ({q, tick, carry, busy} !== exp) begin
        tests_failed++;
        $display("FAIL basic_count k=%0d: got %h expected %h", k, {q, tick, carry, busy}, exp);
      end
    end
  endtask

  task automatic test_terminal_match();
    logic [11:0] exp;
    limit = 8'h05;
    do_load(8'h00);
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      exp = {to_bcd(k < 15 ? k / 3 : 5), (k % 3 == 0 && k <= 15), (k == 15), (k >= 15) ? 2'b11 : 2'b01};
      tests_run++;
      if ({q, tick, done, state} !== exp) begin
        tests_failed++;
        $display("FAIL terminal_match k=%0d: got %h expected %h", k, {q, tick, done, state}, exp);
      end
    end
    start = 1'b1; cyc(); start = 1'b0;
    tests_run++;
    if ({q, state, busy} !== {8'h00, 2'b01, 1'b1}) begin
      tests_failed++;
      $display("FAIL restart_from_done: got %h expected %h", {q, state, busy}, {8'h00, 2'b01, 1'b1});
    end
  endtask

  task automatic test_pause_resume();
    limit = 8'h99;
    do_load(8'h00);
    start = 1'b1; cyc(); start = 1'b0;
    cyc();
    stop = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      tests_run++;
      if ({state, tick, q} !== {2'b10, 1'b0, 8'h00}) begin
        tests_failed++;
        $display("FAIL pause_hold k=%0d: got %h expected %h", k, {state, tick, q}, {2'b10, 1'b0, 8'h00});
      end
    end
    stop = 1'b0; start = 1'b1; cyc(); start = 1'b0;
    cyc();
    tests_run++;
    if ({state, tick, q} !== {2'b01, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL resume_1st: got %h expected %h", {state, tick, q}, {2'b01, 1'b0, 8'h00});
    end
    cyc();
    tests_run++;
    if ({tick, q} !== {1'b1, 8'h01}) begin
      tests_failed++;
      $display("FAIL resume_tick: got %h expected %h", {tick, q}, {1'b1, 8'h01});
    end
    cyc(); cyc(); cyc();
    tests_run++;
    if ({tick, q} !== {1'b1, 8'h02}) begin
      tests_failed++;
      $display("FAIL resume_next_tick: got %h expected %h", {tick, q}, {1'b1, 8'h02});
    end
  endtask

  task automatic test_load_wrap();
    logic [11:0] exp;
    do_load(8'h98);
    tests_run++;
    if ({q, state} !== {8'h98, 2'b00}) begin
      tests_failed++;
      $display("FAIL load_98: got %h expected %h", {q, state}, {8'h98, 2'b00});
    end
    limit = 8'h03;
    start = 1'b1; cyc(); start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      exp = {to_bcd((98 + k / 3) % 100), (k == 6) ? 2'b11 : 2'b00, (k == 15), 1'b0};
      tests_run++;
      if ({q, carry, done, 1'b0} !== exp) begin
        tests_failed++;
        $display("FAIL load_wrap k=%0d: got %h expected %h", k, {q, carry, done, 1'b0}, exp);
      end
    end
    do_load(8'hA7);
    tests_run++;
    if (q !== 8'h07) begin
      tests_failed++;
      $display("FAIL load_nonbcd_A7: got %h expected %h", q, 8'h07);
    end
    do_load(8'h5C);
    tests_run++;
    if (q !== 8'h50) begin
      tests_failed++;
      $display("FAIL load_nonbcd_5C: got %h expected %h", q, 8'h50);
    end
  endtask

  task automatic test_priority();
    limit = 8'h99;
    do_load(8'h09);
    start = 1'b1; cyc(); start = 1'b0;
    cyc(); cyc();
    stop = 1'b1; start = 1'b1; cyc();
    tests_run++;
    if ({state, tick, carry, q} !== {2'b10, 1'b0, 2'b00, 8'h09}) begin
      tests_failed++;
      $display("FAIL stop_beats_start: got %h expected %h", {state, tick, carry, q}, {2'b10, 1'b0, 2'b00, 8'h09});
    end
    stop = 1'b0; cyc(); start = 1'b0;
    load_val = 8'h42; load = 1'b1; cyc(); load = 1'b0;
    tests_run++;
    if ({q, tick, carry, state} !== {8'h42, 1'b0, 2'b00, 2'b00}) begin
      tests_failed++;
      $display("FAIL load_beats_tick: got %h expected %h", {q, tick, carry, state}, {8'h42, 1'b0, 2'b00, 2'b00});
    end
  endtask

  task automatic test_random();
    logic [14:0] exp;
    for (int i = 0; i < 4000; i++) begin
      clr   = ($urandom % 64) != 0;
      load  = ($urandom % 40) == 0;
      stop  = ($urandom % 10) == 0;
      start = ($urandom % 5) == 0;
      load_val = ($urandom % 4 == 0) ? 8'($urandom) : to_bcd($urandom % 100);
      if (i % 150 == 0) limit = ($urandom % 8 == 0) ? 8'($urandom) : to_bcd($urandom % 100);
      cyc();
      exp = {to_bcd(m_n), m_tick, m_carry, (m_state == 1 || m_state == 2), m_done, 2'(m_state)};
      tests_run++;
      if ({q, tick, carry, busy, done, state} !== exp) begin
        tests_failed++;
        $display("FAIL random i=%0d: got %h expected %h", i, {q, tick, carry, busy, done, state}, exp);
      end
    end
    clr = 1'b1; load = 1'b0; stop = 1'b0; start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_terminal_match();
    test_pause_resume();
    test_load_wrap();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
